ray_scheduler: RTL and testbench
================================

RAY_SCHEDULER -- requirements
Module: ray_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720, meaning frame height in pixels.
REQ-003 SHALL have parameter NUM_CORES, default 4, meaning number of ray_tracer cores served (1..8).
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port frame_start, input, 1 bit: single-cycle request to render one frame.
REQ-007 SHALL have port frame_busy, output, 1 bit: frame in progress.
REQ-008 SHALL have port frame_done, output, 1 bit: single-cycle pulse when the frame is complete.
REQ-009 SHALL have port core_start, output, NUM_CORES bits: one-hot pulse that dispatches a pixel to core i.
REQ-010 SHALL have ports core_h and core_v, outputs, NUM_CORES x 11 and NUM_CORES x 10 bits: per-core pixel coordinates, held stable from dispatch until the result drains.
REQ-011 SHALL have port core_done, input, NUM_CORES bits: core i ray_done pulse.
REQ-012 SHALL have port core_color, input, NUM_CORES x fp_vec3: core i pixel_color, valid with core_done[i].
REQ-013 SHALL have ports wr_valid (output, 1 bit), wr_ready (input, 1 bit), wr_h (output, 11 bits), wr_v (output, 10 bits) and wr_color (output, fp_vec3): the framebuffer write port.

Function
REQ-014 SHALL use states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE: frame_start SHALL go to RUN and clear the pixel counter to (0,0); in all other states frame_start SHALL be ignored.
REQ-016 Each core SHALL be tracked as FREE, BUSY (dispatched, awaiting core_done) or PEND (result latched, awaiting write).
REQ-017 In RUN, while pixels remain, the lowest-index FREE core SHALL receive a core_start pulse each cycle; at most one dispatch per cycle.
REQ-018 At dispatch, core_h/core_v SHALL register the current pixel and the counter SHALL advance in raster order: h+1, wrap h=WIDTH-1 to 0 with v+1.
REQ-019 A core that is dispatched SHALL go to BUSY the next cycle, and the same core SHALL NOT be re-dispatched until it returns to FREE.
REQ-020 On core_done[i] while BUSY, core_color[i] SHALL be latched and the core SHALL go to PEND; core_done for a core not BUSY SHALL be ignored.
REQ-021 Round-robin arbitration among PEND cores SHALL drive the write port; priority SHALL start after the last granted index, and index 0 SHALL be first after reset.
REQ-022 wr_valid SHALL be registered, and wr_h/wr_v/wr_color SHALL be held stable while wr_valid=1 and wr_ready=0.
REQ-023 A write SHALL complete when wr_valid and wr_ready are both 1; the granted core SHALL become FREE the next cycle and can be redispatched no earlier than that cycle.
REQ-024 Simultaneous core_done on several cores SHALL all be latched in the same cycle, with none lost.
REQ-025 After pixel (WIDTH-1,HEIGHT-1) is dispatched, the block SHALL go to DRAIN; when all cores are FREE and wr_valid=0, it SHALL go to DONE.
REQ-026 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE.
REQ-027 frame_busy SHALL be 1 in RUN and DRAIN.
REQ-028 Throughput: with wr_ready held at 1, a core's turnaround from core_done to its next core_start SHALL be at most 3 cycles.

Reset
REQ-029 rst SHALL force state IDLE, all cores FREE, the pixel counter to (0,0), the round-robin pointer to 0, and core_start=0, wr_valid=0, frame_busy=0, frame_done=0.
REQ-030 rst SHALL force core_h=0, core_v=0, wr_h=0, wr_v=0 and wr_color=0.
REQ-031 rst mid-frame SHALL abandon the frame without a frame_done pulse, and subsequent core_done pulses SHALL be ignored.

Structure
REQ-032 fp_vec3, pixel coordinate widths and MAX_CORES SHALL come from the shared rtx package; no new typedefs SHALL be defined locally.
REQ-033 The round-robin arbiter SHALL be one sub-module, rr_arbiter (parameterised N, request vector in, one-hot grant out, advance input).

Verification
REQ-034 WIDTH=4, HEIGHT=2, NUM_CORES=2, cores respond 5 cycles after start, wr_ready=1 -> 8 writes covering every (h,v) exactly once, then exactly one frame_done, with frame_busy low afterwards.
REQ-035 core_done on cores 0 and 1 in the same cycle, wr_ready=0 for 10 cycles -> wr_valid held with the core 0 result stable; after wr_ready rises, core 0 writes, then core 1.
REQ-036 NUM_CORES=4, all cores PEND, wr_ready=1 -> grants in order 0,1,2,3, one per handshake, with no repeats.
REQ-037 frame_start pulsed during RUN -> no effect; pixel sequence and write count unchanged.
REQ-038 rst asserted after 3 dispatches -> all outputs at reset values next cycle, no frame_done, and a later core_done produces no write.
REQ-039 WIDTH=1, HEIGHT=1 -> exactly one core_start to core 0 at (0,0), one write, then frame_done.

Source files
------------

// File: rtl/rtx_pkg.sv
// Shared ray-tracing types: fixed-point vectors, pixel coordinates,
// scheduler and per-core state encodings.
package rtx_pkg;

    localparam int MAX_CORES = 8;
    localparam int H_W       = 11;
    localparam int V_W       = 10;
    localparam int FP_W      = 32;

    typedef logic signed [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } fp_vec3;

    localparam int VEC_W = $bits(fp_vec3);

    typedef logic [H_W-1:0] coord_h_t;
    typedef logic [V_W-1:0] coord_v_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        PEND
    } core_state_t;

endpackage

// File: rtl/ray_scheduler_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted index.
// The pointer only moves when the caller consumes the grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Scan requests starting at the pointer, wrapping once.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Move priority past the index that was just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            if (int'(gidx) == N - 1) ptr <= '0;
            else                     ptr <= gidx + 1'b1;
        end
    end

endmodule

// File: rtl/ray_scheduler.sv
// Frame scheduler: hands pixels to ray_tracer cores in raster order
// and funnels their colours to the framebuffer write port.
module ray_scheduler
    import rtx_pkg::*;
#(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int NUM_CORES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    output logic                     frame_busy,
    output logic                     frame_done,
    output logic [NUM_CORES-1:0]     core_start,
    output logic [NUM_CORES*H_W-1:0] core_h,
    output logic [NUM_CORES*V_W-1:0] core_v,
    input  logic [NUM_CORES-1:0]     core_done,
    input  logic [NUM_CORES*VEC_W-1:0] core_color,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [H_W-1:0]           wr_h,
    output logic [V_W-1:0]           wr_v,
    output fp_vec3                   wr_color
);

    localparam coord_h_t H_LAST = coord_h_t'(WIDTH - 1);
    localparam coord_v_t V_LAST = coord_v_t'(HEIGHT - 1);

    sched_state_t state, state_nxt;
    core_state_t  cst   [NUM_CORES];
    coord_h_t     ch_q  [NUM_CORES];
    coord_v_t     cv_q  [NUM_CORES];
    fp_vec3       col_q [NUM_CORES];

    coord_h_t cnt_h;
    coord_v_t cnt_v;
    logic     last_pix;

    logic [NUM_CORES-1:0] free_m, pend_m, disp;
    logic [NUM_CORES-1:0] req, grant, wr_core;
    logic                 disp_found;
    logic                 load, wr_fire, advance;
    coord_h_t             sel_h;
    coord_v_t             sel_v;
    fp_vec3               sel_col;

    assign last_pix = (cnt_h == H_LAST) && (cnt_v == V_LAST);
    assign wr_fire  = wr_valid && wr_ready;
    assign load     = !wr_valid || wr_ready;
    assign req      = pend_m & ~(wr_valid ? wr_core : '0);
    assign advance  = load && (|req);

    // Core status masks and lowest-index free core.
    always_comb begin
        free_m     = '0;
        pend_m     = '0;
        disp       = '0;
        disp_found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            free_m[i] = (cst[i] == FREE);
            pend_m[i] = (cst[i] == PEND);
            if (!disp_found && free_m[i]) begin
                disp[i]    = 1'b1;
                disp_found = 1'b1;
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, dispatch pulse and frame status.
    always_comb begin
        state_nxt  = state;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        core_start = '0;
        unique case (state)
            IDLE: begin
                if (frame_start) state_nxt = RUN;
            end
            RUN: begin
                frame_busy = 1'b1;
                core_start = disp;
                if (disp_found && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                frame_busy = 1'b1;
                if ((&free_m) && !wr_valid) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
        endcase
    end

    // Coordinates appear with the start pulse, then stay latched.
    always_comb begin
        core_h = '0;
        core_v = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_h[i*H_W +: H_W] = core_start[i] ? cnt_h : ch_q[i];
            core_v[i*V_W +: V_W] = core_start[i] ? cnt_v : cv_q[i];
        end
    end

    // Raster pixel counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (state == IDLE && frame_start) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (|core_start) begin
            if (cnt_h == H_LAST) begin
                cnt_h <= '0;
                cnt_v <= cnt_v + 1'b1;
            end else begin
                cnt_h <= cnt_h + 1'b1;
            end
        end
    end

    // Per-core lifecycle FREE -> BUSY -> PEND -> FREE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                cst[i]   <= FREE;
                ch_q[i]  <= '0;
                cv_q[i]  <= '0;
                col_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                case (cst[i])
                    FREE: if (core_start[i]) begin
                        cst[i]  <= BUSY;
                        ch_q[i] <= cnt_h;
                        cv_q[i] <= cnt_v;
                    end
                    BUSY: if (core_done[i]) begin
                        cst[i]   <= PEND;
                        col_q[i] <= core_color[i*VEC_W +: VEC_W];
                    end
                    PEND: if (wr_fire && wr_core[i]) cst[i] <= FREE;
                    default: cst[i] <= FREE;
                endcase
            end
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    // Select the granted core's latched result.
    always_comb begin
        sel_h   = '0;
        sel_v   = '0;
        sel_col = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_h   = ch_q[i];
                sel_v   = cv_q[i];
                sel_col = col_q[i];
            end
        end
    end

    // Registered write port; reloads only when empty or accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_core  <= '0;
            wr_h     <= '0;
            wr_v     <= '0;
            wr_color <= '0;
        end else if (load) begin
            wr_valid <= |req;
            if (|req) begin
                wr_core  <= grant;
                wr_h     <= sel_h;
                wr_v     <= sel_v;
                wr_color <= sel_col;
            end
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// Scoreboard bench for ray_scheduler: three instances cover the
// 4x2/2-core frame, the 4-core arbitration case and the 1x1 frame.
module tb_ray_scheduler;
    import rtx_pkg::*;

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [95:0] c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Instance A: 4x2, 2 cores
    logic         rst_a = 1'b1, fs_a = 1'b0, wrdy_a = 1'b1;
    logic         busy_a, fdn_a, wv_a;
    logic [1:0]   cs_a;
    logic [1:0]   done_a = '0;
    logic [21:0]  ch_a;
    logic [19:0]  cv_a;
    logic [191:0] color_a = '0;
    logic [10:0]  wh_a;
    logic [9:0]   wvv_a;
    fp_vec3       wc_col_a;

    // Instance B: 4x1, 4 cores
    logic         rst_bc = 1'b1, fs_b = 1'b0, wrdy_b = 1'b1;
    logic         busy_b, fdn_b, wv_b;
    logic [3:0]   cs_b;
    logic [3:0]   done_b = '0;
    logic [43:0]  ch_b;
    logic [39:0]  cv_b;
    logic [383:0] color_b = '0;
    logic [10:0]  wh_b;
    logic [9:0]   wvv_b;
    fp_vec3       wc_col_b;

    // Instance C: 1x1, 2 cores
    logic         fs_c = 1'b0, wrdy_c = 1'b1;
    logic         busy_c, fdn_c, wv_c;
    logic [1:0]   cs_c;
    logic [1:0]   done_c = '0;
    logic [21:0]  ch_c;
    logic [19:0]  cv_c;
    logic [191:0] color_c = '0;
    logic [10:0]  wh_c;
    logic [9:0]   wvv_c;
    fp_vec3       wc_col_c;

    ray_scheduler #(.WIDTH(4), .HEIGHT(2), .NUM_CORES(2)) dut_a (
        .clk(clk), .rst(rst_a), .frame_start(fs_a),
        .frame_busy(busy_a), .frame_done(fdn_a),
        .core_start(cs_a), .core_h(ch_a), .core_v(cv_a),
        .core_done(done_a), .core_color(color_a),
        .wr_valid(wv_a), .wr_ready(wrdy_a),
        .wr_h(wh_a), .wr_v(wvv_a), .wr_color(wc_col_a)
    );

    ray_scheduler #(.WIDTH(4), .HEIGHT(1), .NUM_CORES(4)) dut_b (
        .clk(clk), .rst(rst_bc), .frame_start(fs_b),
        .frame_busy(busy_b), .frame_done(fdn_b),
        .core_start(cs_b), .core_h(ch_b), .core_v(cv_b),
        .core_done(done_b), .core_color(color_b),
        .wr_valid(wv_b), .wr_ready(wrdy_b),
        .wr_h(wh_b), .wr_v(wvv_b), .wr_color(wc_col_b)
    );

    ray_scheduler #(.WIDTH(1), .HEIGHT(1), .NUM_CORES(2)) dut_c (
        .clk(clk), .rst(rst_bc), .frame_start(fs_c),
        .frame_busy(busy_c), .frame_done(fdn_c),
        .core_start(cs_c), .core_h(ch_c), .core_v(cv_c),
        .core_done(done_c), .core_color(color_c),
        .wr_valid(wv_c), .wr_ready(wrdy_c),
        .wr_h(wh_c), .wr_v(wvv_c), .wr_color(wc_col_c)
    );

    function automatic logic [95:0] f(input int h, input int v);
        return {32'(h + 100), 32'(v + 200), 32'(h * 16 + v + 7)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int fd_a = 0, fd_b = 0, fd_c = 0;
    int wc_a = 0, wc_b = 0, wc_c = 0;

    // Write monitors: pop expected entry on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (fdn_a) fd_a++;
        if (wv_a && wrdy_a) begin
            wc_a++;
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_extra_write: got h=%0d v=%0d want none",
                         wh_a, wvv_a);
            end else begin
                e = qa.pop_front();
                chk("a_wr_h", 128'(wh_a), 128'(e.h));
                chk("a_wr_v", 128'(wvv_a), 128'(e.v));
                chk("a_wr_color", 128'(wc_col_a), 128'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fdn_b) fd_b++;
        if (wv_b && wrdy_b) begin
            wc_b++;
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_extra_write: got h=%0d want none", wh_b);
            end else begin
                e = qb.pop_front();
                chk("b_wr_h", 128'(wh_b), 128'(e.h));
                chk("b_wr_v", 128'(wvv_b), 128'(e.v));
                chk("b_wr_color", 128'(wc_col_b), 128'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (fdn_c) fd_c++;
        if (wv_c && wrdy_c) begin
            wc_c++;
            if (qc.size() == 0) begin
                total++; bad++;
                $display("FAIL c_extra_write: got h=%0d want none", wh_c);
            end else begin
                e = qc.pop_front();
                chk("c_wr_h", 128'(wh_c), 128'(e.h));
                chk("c_wr_v", 128'(wvv_c), 128'(e.v));
                chk("c_wr_color", 128'(wc_col_c), 128'(e.c));
            end
        end
    end

    // Core model for instance A: fixed per-core latency, colour from (h,v).
    int lat_a [2] = '{5, 5};
    int cnt_a [2] = '{0, 0};
    int hh    [2] = '{0, 0};
    int vv    [2] = '{0, 0};
    int dcyc  [2] = '{0, 0};
    bit dpend [2] = '{0, 0};
    bit tp_on = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                done_a[i] = 1'b0;
                if (cnt_a[i] > 0) begin
                    cnt_a[i]--;
                    if (cnt_a[i] == 0) begin
                        done_a[i] = 1'b1;
                        color_a[i*96 +: 96] = f(hh[i], vv[i]);
                        dcyc[i]  = cyc;
                        dpend[i] = 1'b1;
                    end
                end
                if (cs_a[i]) begin
                    if (tp_on && dpend[i])
                        chk("a_turnaround_le3", 128'((cyc - dcyc[i]) <= 3),
                            128'(1));
                    dpend[i] = 1'b0;
                    cnt_a[i] = lat_a[i];
                    hh[i] = int'(ch_a[i*11 +: 11]);
                    vv[i] = int'(cv_a[i*10 +: 10]);
                end
            end
        end
    end

    task automatic push_a();
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < 4; h++)
                qa.push_back('{h: 11'(h), v: 10'(v), c: f(h, v)});
    endtask

    task automatic pulse_fs_a();
        @(negedge clk) fs_a = 1'b1;
        @(negedge clk) fs_a = 1'b0;
    endtask

    task automatic wait_fd_a(input int target, input int maxc);
        int n = 0;
        while (fd_a < target && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("a_frame_done_seen", 128'(fd_a >= target), 128'(1));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"},  128'(busy_a), 128'(0));
        chk({tag, "_done"},  128'(fdn_a), 128'(0));
        chk({tag, "_start"}, 128'(cs_a), 128'(0));
        chk({tag, "_wv"},    128'(wv_a), 128'(0));
        chk({tag, "_ch"},    128'(ch_a), 128'(0));
        chk({tag, "_cv"},    128'(cv_a), 128'(0));
        chk({tag, "_wh"},    128'(wh_a), 128'(0));
        chk({tag, "_wvv"},   128'(wvv_a), 128'(0));
        chk({tag, "_wcol"},  128'(wc_col_a), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int starts;
        repeat (3) @(negedge clk);
        chk_reset_a("rst");
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        // Full frame, 2 cores, latency 5, wr_ready high.
        tp_on = 1'b1;
        push_a();
        pulse_fs_a();
        chk("a_busy_run", 128'(busy_a), 128'(1));
        wait_fd_a(1, 300);
        repeat (3) @(negedge clk);
        tp_on = 1'b0;
        chk("a_f1_writes", 128'(wc_a), 128'(8));
        chk("a_f1_queue", 128'(qa.size()), 128'(0));
        chk("a_f1_one_done", 128'(fd_a), 128'(1));
        chk("a_f1_busy_low", 128'(busy_a), 128'(0));

        // Simultaneous completion with a stalled write port.
        lat_a[0] = 6;
        lat_a[1] = 5;
        wrdy_a   = 1'b0;
        push_a();
        pulse_fs_a();
        n = 0;
        while (!wv_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("a_hold_valid", 128'(wv_a), 128'(1));
            chk("a_hold_h", 128'(wh_a), 128'(0));
            chk("a_hold_v", 128'(wvv_a), 128'(0));
            chk("a_hold_color", 128'(wc_col_a), 128'(f(0, 0)));
            @(negedge clk);
        end
        wrdy_a = 1'b1;
        wait_fd_a(2, 300);
        repeat (3) @(negedge clk);
        chk("a_f2_writes", 128'(wc_a), 128'(16));
        chk("a_f2_queue", 128'(qa.size()), 128'(0));

        // frame_start pulses during RUN must be ignored.
        lat_a[0] = 5;
        push_a();
        pulse_fs_a();
        repeat (4) @(negedge clk);
        fs_a = 1'b1;
        @(negedge clk) fs_a = 1'b0;
        repeat (9) @(negedge clk);
        fs_a = 1'b1;
        @(negedge clk) fs_a = 1'b0;
        wait_fd_a(3, 300);
        repeat (5) @(negedge clk);
        chk("a_f3_writes", 128'(wc_a), 128'(24));
        chk("a_f3_queue", 128'(qa.size()), 128'(0));
        chk("a_f3_done_cnt", 128'(fd_a), 128'(3));
        chk("a_f3_busy_low", 128'(busy_a), 128'(0));

        // Reset after the third dispatch.
        push_a();
        pulse_fs_a();
        starts = 0;
        n = 0;
        while (starts < 3 && n < 100) begin
            starts += $countones(cs_a);
            if (starts < 3) @(negedge clk);
            n++;
        end
        chk("a_three_starts", 128'(starts), 128'(3));
        rst_a = 1'b1;
        @(negedge clk);
        chk_reset_a("midrst");
        rst_a = 1'b0;
        qa.delete();
        repeat (25) @(negedge clk);
        chk("a_rst_writes", 128'(wc_a), 128'(26));
        chk("a_rst_no_done", 128'(fd_a), 128'(3));
        chk("a_rst_idle", 128'(busy_a), 128'(0));

        // Four cores all pending: grants 0,1,2,3.
        for (int h = 0; h < 4; h++)
            qb.push_back('{h: 11'(h), v: 10'(0), c: f(h, 0)});
        @(negedge clk) fs_b = 1'b1;
        @(negedge clk) fs_b = 1'b0;
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            if (cs_b != 4'd0) begin
                chk("b_start_order", 128'(cs_b), 128'(4'd1 << k));
                k++;
            end
            @(negedge clk);
            n++;
        end
        chk("b_four_starts", 128'(k), 128'(4));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) color_b[i*96 +: 96] = f(i, 0);
        done_b = 4'hF;
        @(negedge clk) done_b = 4'h0;
        n = 0;
        while (fd_b < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("b_done_cnt", 128'(fd_b), 128'(1));
        chk("b_writes", 128'(wc_b), 128'(4));
        chk("b_queue", 128'(qb.size()), 128'(0));

        // 1x1 frame.
        qc.push_back('{h: 11'(0), v: 10'(0), c: f(0, 0)});
        @(negedge clk) fs_c = 1'b1;
        @(negedge clk) fs_c = 1'b0;
        n = 0;
        while (cs_c == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("c_start_core0", 128'(cs_c), 128'(2'b01));
        chk("c_start_h", 128'(ch_c[10:0]), 128'(0));
        chk("c_start_v", 128'(cv_c[9:0]), 128'(0));
        starts = 0;
        repeat (2) @(negedge clk);
        color_c[95:0] = f(0, 0);
        done_c = 2'b01;
        @(negedge clk) done_c = 2'b00;
        for (int i = 0; i < 30; i++) begin
            starts += $countones(cs_c);
            @(negedge clk);
        end
        chk("c_no_more_starts", 128'(starts), 128'(0));
        chk("c_done_cnt", 128'(fd_c), 128'(1));
        chk("c_writes", 128'(wc_c), 128'(1));
        chk("c_busy_low", 128'(busy_c), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
